// File: rtl/button_bank_pkg.sv
// Shared defaults for the button bank.
// Per-channel constants derive from these.
package button_bank_pkg;

  localparam int DEF_N_BTN       = 4;
  localparam int DEF_CTR_SZ      = 19;
  localparam int DEF_SYNC_STAGES = 4;
  localparam int DEF_LONG_SZ     = 25;

endpackage

// File: rtl/button_chan.sv
// One button channel: polarity, synchroniser, symmetric debounce, hold timer and event pulses.
// `release` is a reserved word, so the release pulse is named release_pulse.
module button_chan
  import button_bank_pkg::*;
#(
  parameter int CTR_SZ      = DEF_CTR_SZ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LONG_SZ     = DEF_LONG_SZ,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic state,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CTR_SZ-1:0]  CTR_ONE  = CTR_SZ'(1);
  localparam logic [LONG_SZ-1:0] HOLD_ONE = LONG_SZ'(1);

  logic raw;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic synced;
  logic [CTR_SZ-1:0] cnt;
  logic flip;
  logic [LONG_SZ-1:0] hold;
  logic long_done;

  // Polarity is folded in ahead of the first flop, so every stage means pressed=1.
  assign raw    = btn ^ ACTIVE_LOW;
  assign synced = sync[SYNC_STAGES-1];
  assign flip   = (synced != state) && (cnt == '1);

  // NOTE: every register here uses <= so all flops see the pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      state         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= flip & ~state;
      release_pulse <= flip & state;
      if (synced == state) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        state <= ~state;
      end else begin
        cnt <= cnt + CTR_ONE;
      end
    end
  end

  // long_done holds off a second long_press until the button is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      long_done  <= 1'b0;
      long_press <= 1'b0;
    end else if (!state) begin
      hold       <= '0;
      long_done  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      if (hold != '1) hold <= hold + HOLD_ONE;
      long_press <= (hold == '1) && !long_done;
      if (hold == '1) long_done <= 1'b1;
    end
  end

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced button channels plus a combined event flag.
// any_event is an OR of registered pulses, so it is glitch-free and has no path from btn.
module button_bank
  import button_bank_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int CTR_SZ      = DEF_CTR_SZ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter int LONG_SZ     = DEF_LONG_SZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] state,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic             any_event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_chan #(
      .CTR_SZ      (CTR_SZ),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_SZ     (LONG_SZ),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn[i]),
      .state         (state[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

  assign any_event = |{press, release_pulse, long_press};

endmodule
